// File: rtl/mode_counter_pkg.sv
// Shared definitions for the multi-mode counter: mode encodings.
package mode_counter_pkg;

  localparam logic [1:0] MODE_UP   = 2'b00;
  localparam logic [1:0] MODE_DOWN = 2'b01;
  localparam logic [1:0] MODE_PING = 2'b10;
  localparam logic [1:0] MODE_HOLD = 2'b11;

endpackage

// File: rtl/ctr_prescaler.sv
// Prescaler for mode_counter: emits a tick every (prescale+1) enabled cycles.
//  clk, rst_n  : clock, synchronous active-low reset
//  en          : advance the prescaler; 0 freezes it
//  clear       : restart the prescaler from 0 (used on load)
//  prescale    : divisor minus one
//  tick_c      : combinational tick, high in the cycle the counter should step
module ctr_prescaler #(
  parameter int unsigned PRESCALE_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  clear,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  tick_c
);

  logic [PRESCALE_W-1:0] pre_q, pre_d;

  assign tick_c = en && (pre_q == prescale);

  // Next prescaler value: clear wins, then wrap on terminal count, else advance.
  always_comb begin
    pre_d = pre_q;
    if (clear) begin
      pre_d = '0;
    end else if (en) begin
      if (pre_q == prescale) pre_d = '0;
      else                   pre_d = pre_q + PRESCALE_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) pre_q <= '0;
    else        pre_q <= pre_d;
  end

endmodule

// File: rtl/mode_counter.sv
// Multi-mode counter/timer with prescaler, modulo, up/down/ping-pong/hold modes,
// synchronous load and single-cycle step/wrap/match pulses.
//  clk, rst_n : clock, synchronous active-low reset
//  en         : run the prescaler (count frozen when 0)
//  mode       : 00 up, 01 down, 10 ping-pong, 11 hold
//  load       : load strobe, wins over a step; load_val clamped to modulo
//  modulo     : top of count range 0..modulo
//  prescale   : step every (prescale+1) enabled cycles
//  cmp_val    : compare value for match
//  count, dir : registered count and ping-pong direction (0 up, 1 down)
//  step, wrap, match : registered single-cycle event pulses
module mode_counter
  import mode_counter_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned PRESCALE_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [1:0]            mode,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_val,
  input  logic [WIDTH-1:0]      modulo,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic [WIDTH-1:0]      cmp_val,
  output logic [WIDTH-1:0]      count,
  output logic                  dir,
  output logic                  step,
  output logic                  wrap,
  output logic                  match
);

  logic             tick_c;
  logic [WIDTH-1:0] count_q, count_d;
  logic             dir_q, dir_d;
  logic             step_q, step_d;
  logic             wrap_q, wrap_d;
  logic             match_q, match_d;
  logic [WIDTH-1:0] load_clamped_c;

  ctr_prescaler #(.PRESCALE_W(PRESCALE_W)) u_prescaler (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .clear    (load),
    .prescale (prescale),
    .tick_c   (tick_c)
  );

  assign load_clamped_c = (load_val > modulo) ? modulo : load_val;

  // Next count, direction and event pulses; pulses default low.
  always_comb begin
    count_d = count_q;
    dir_d   = dir_q;
    step_d  = 1'b0;
    wrap_d  = 1'b0;
    match_d = 1'b0;
    if (load) begin
      count_d = load_clamped_c;
      dir_d   = 1'b0;
      match_d = (load_clamped_c == cmp_val);
    end else if (tick_c) begin
      step_d = 1'b1;
      unique case (mode)
        MODE_UP: begin
          // >= so that a count left above a shrunk modulo wraps immediately
          if (count_q >= modulo) begin
            count_d = '0;
            wrap_d  = 1'b1;
          end else begin
            count_d = count_q + WIDTH'(1);
          end
        end
        MODE_DOWN: begin
          if (count_q == '0) begin
            count_d = modulo;
            wrap_d  = 1'b1;
          end else begin
            count_d = count_q - WIDTH'(1);
          end
        end
        MODE_PING: begin
          if (modulo == '0) begin
            // degenerate range: every step is a turn
            count_d = '0;
            wrap_d  = 1'b1;
          end else if (!dir_q) begin
            if (count_q >= modulo) begin
              dir_d   = 1'b1;
              count_d = modulo - WIDTH'(1);
              wrap_d  = 1'b1;
            end else begin
              count_d = count_q + WIDTH'(1);
            end
          end else begin
            if (count_q == '0) begin
              dir_d   = 1'b0;
              count_d = WIDTH'(1);
              wrap_d  = 1'b1;
            end else begin
              count_d = count_q - WIDTH'(1);
            end
          end
        end
        MODE_HOLD: begin
          count_d = count_q;
        end
        default: begin
          count_d = count_q;
        end
      endcase
      // match only on a value that actually changed
      match_d = (count_d != count_q) && (count_d == cmp_val);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
      dir_q   <= 1'b0;
      step_q  <= 1'b0;
      wrap_q  <= 1'b0;
      match_q <= 1'b0;
    end else begin
      count_q <= count_d;
      dir_q   <= dir_d;
      step_q  <= step_d;
      wrap_q  <= wrap_d;
      match_q <= match_d;
    end
  end

  assign count = count_q;
  assign dir   = dir_q;
  assign step  = step_q;
  assign wrap  = wrap_q;
  assign match = match_q;

endmodule

// File: tb/tb_mode_counter.sv
// Directed, table-driven bench for mode_counter (WIDTH=8, PRESCALE_W=4).
module tb_mode_counter;

  localparam logic [1:0] UP   = 2'b00;
  localparam logic [1:0] DOWN = 2'b01;
  localparam logic [1:0] PING = 2'b10;
  localparam logic [1:0] HOLD = 2'b11;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [1:0] mode;
  logic       load;
  logic [7:0] load_val;
  logic [7:0] modulo;
  logic [3:0] prescale;
  logic [7:0] cmp_val;
  logic [7:0] count;
  logic       dir;
  logic       step;
  logic       wrap;
  logic       match;

  int tests  = 0;
  int errors = 0;

  typedef struct {
    logic       rst_n;
    logic       en;
    logic [1:0] mode;
    logic       load;
    logic [7:0] load_val;
    logic [7:0] modulo;
    logic [3:0] prescale;
    logic [7:0] cmp_val;
    logic [7:0] e_count;
    logic       e_dir;
    logic       e_step;
    logic       e_wrap;
    logic       e_match;
  } vec_t;

  vec_t vecs[$];

  mode_counter #(.WIDTH(8), .PRESCALE_W(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .mode     (mode),
    .load     (load),
    .load_val (load_val),
    .modulo   (modulo),
    .prescale (prescale),
    .cmp_val  (cmp_val),
    .count    (count),
    .dir      (dir),
    .step     (step),
    .wrap     (wrap),
    .match    (match)
  );

  always #5 clk = ~clk;

  task automatic add(input logic r, input logic e, input logic [1:0] m, input logic ld,
                     input logic [7:0] lv, input logic [7:0] mo, input logic [3:0] ps,
                     input logic [7:0] cv, input logic [7:0] ec, input logic ed,
                     input logic es, input logic ew, input logic em);
    vec_t v;
    v.rst_n = r; v.en = e; v.mode = m; v.load = ld; v.load_val = lv;
    v.modulo = mo; v.prescale = ps; v.cmp_val = cv;
    v.e_count = ec; v.e_dir = ed; v.e_step = es; v.e_wrap = ew; v.e_match = em;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [7:0] ec, input logic ed,
                       input logic es, input logic ew, input logic em);
    tests++;
    if (count !== ec || dir !== ed || step !== es || wrap !== ew || match !== em) begin
      errors++;
      $display("FAIL %s: got count=%0d dir=%b step=%b wrap=%b match=%b, want count=%0d dir=%b step=%b wrap=%b match=%b",
               name, count, dir, step, wrap, match, ec, ed, es, ew, em);
    end
  endtask

  initial begin
    int cycles;
    // reset with junk inputs
    add(0,1,PING,1,8'h55,8'hAA,4'h0,8'h00, 0,0,0,0,0);
    add(0,1,PING,1,8'h55,8'hAA,4'h0,8'h00, 0,0,0,0,0);
    // up, modulo 5, prescale 0, cmp 3
    add(1,1,UP,0,0,5,0,3, 1,0,1,0,0);
    add(1,1,UP,0,0,5,0,3, 2,0,1,0,0);
    add(1,1,UP,0,0,5,0,3, 3,0,1,0,1);
    add(1,1,UP,0,0,5,0,3, 4,0,1,0,0);
    add(1,1,UP,0,0,5,0,3, 5,0,1,0,0);
    add(1,1,UP,0,0,5,0,3, 0,0,1,1,0);
    add(1,1,UP,0,0,5,0,3, 1,0,1,0,0);
    // load 0, then prescale 3: step every 4th enabled cycle
    add(1,1,UP,1,0,5,3,8'hFF, 0,0,0,0,0);
    for (int i = 0; i < 3; i++) add(1,1,UP,0,0,5,3,8'hFF, 0,0,0,0,0);
    add(1,1,UP,0,0,5,3,8'hFF, 1,0,1,0,0);
    for (int i = 0; i < 3; i++) add(1,1,UP,0,0,5,3,8'hFF, 1,0,0,0,0);
    add(1,1,UP,0,0,5,3,8'hFF, 2,0,1,0,0);
    for (int i = 0; i < 2; i++) add(1,1,UP,0,0,5,3,8'hFF, 2,0,0,0,0);
    // en=0 freezes prescaler and count
    for (int i = 0; i < 10; i++) add(1,0,UP,0,0,5,3,8'hFF, 2,0,0,0,0);
    add(1,1,UP,0,0,5,3,8'hFF, 2,0,0,0,0);
    add(1,1,UP,0,0,5,3,8'hFF, 3,0,1,0,0);
    // ping-pong, modulo 3
    add(1,1,PING,1,0,3,0,8'hFF, 0,0,0,0,0);
    add(1,1,PING,0,0,3,0,8'hFF, 1,0,1,0,0);
    add(1,1,PING,0,0,3,0,8'hFF, 2,0,1,0,0);
    add(1,1,PING,0,0,3,0,8'hFF, 3,0,1,0,0);
    add(1,1,PING,0,0,3,0,8'hFF, 2,1,1,1,0);
    add(1,1,PING,0,0,3,0,8'hFF, 1,1,1,0,0);
    add(1,1,PING,0,0,3,0,8'hFF, 0,1,1,0,0);
    add(1,1,PING,0,0,3,0,8'hFF, 1,0,1,1,0);
    add(1,1,PING,0,0,3,0,8'hFF, 2,0,1,0,0);
    add(1,1,PING,0,0,3,0,8'hFF, 3,0,1,0,0);
    add(1,1,PING,0,0,3,0,8'hFF, 2,1,1,1,0);
    // load 9 clamped to modulo 6 with a tick pending; dir cleared
    add(1,1,UP,1,9,6,0,6, 6,0,0,0,1);
    add(1,1,UP,0,9,6,0,6, 0,0,1,1,0);
    // down, modulo 4, cmp 2, then reset mid-run (reset beats load)
    add(1,1,DOWN,0,0,4,0,2, 4,0,1,1,0);
    add(1,1,DOWN,0,0,4,0,2, 3,0,1,0,0);
    add(1,1,DOWN,0,0,4,0,2, 2,0,1,0,1);
    add(1,1,DOWN,0,0,4,0,2, 1,0,1,0,0);
    add(0,1,DOWN,1,7,4,0,2, 0,0,0,0,0);
    add(1,0,DOWN,0,0,4,0,2, 0,0,0,0,0);
    // hold: step only, no match even when count == cmp
    add(1,1,HOLD,0,0,4,0,0, 0,0,1,0,0);
    // modulo shrunk below count: up wraps to 0
    add(1,1,UP,1,9,10,0,8'hFF, 9,0,0,0,0);
    add(1,1,UP,0,9,5,0,8'hFF, 0,0,1,1,0);
    // modulo shrunk below count: down decrements normally
    add(1,1,UP,1,9,10,0,8'hFF, 9,0,0,0,0);
    add(1,1,DOWN,0,9,4,0,8'hFF, 8,0,1,0,0);
    // ping-pong with modulo 0: stays 0, wrap each step, no match
    add(1,1,PING,1,0,0,0,0, 0,0,0,0,1);
    add(1,1,PING,0,0,0,0,0, 0,0,1,1,0);

    foreach (vecs[i]) begin
      rst_n = vecs[i].rst_n; en = vecs[i].en; mode = vecs[i].mode;
      load = vecs[i].load; load_val = vecs[i].load_val; modulo = vecs[i].modulo;
      prescale = vecs[i].prescale; cmp_val = vecs[i].cmp_val;
      @(posedge clk); #1;
      check($sformatf("vec%0d", i), vecs[i].e_count, vecs[i].e_dir,
            vecs[i].e_step, vecs[i].e_wrap, vecs[i].e_match);
    end

    // latency with the largest prescale: first step 16 enabled cycles after load
    rst_n = 1; en = 1; mode = UP; load = 1; load_val = 0; modulo = 200;
    prescale = 4'hF; cmp_val = 8'hFF;
    @(posedge clk); #1;
    load = 0;
    cycles = 0;
    while (cycles < 100) begin
      @(posedge clk); #1;
      cycles++;
      if (step) break;
    end
    tests++;
    if (cycles != 16) begin
      errors++;
      $display("FAIL latency: got %0d cycles, want 16", cycles);
    end
    check("latency_val", 1, 0, 1, 0, 0);
    // pulse is a single cycle
    @(posedge clk); #1;
    check("pulse_width", 1, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
